ln_lut_search: RTL and testbench
================================

LN_LUT_SEARCH -- requirements
Module: ln_lut_search

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 1_000_000, the number of entries in the external exp table.
REQ-002 SHALL have parameter ADDR_W, default 20, the table address width and the fixed binary-search iteration count.
REQ-003 SHALL have parameter STEP_Q, default 8590, the q32.32 index-to-value step, round(2^33/(ARRAY_SIZE-1)).
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock.
REQ-005 SHALL have port i_rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1 bit, request strobe.
REQ-007 SHALL have port i_value, input, 64 bits, unsigned q32.32 operand x.
REQ-008 SHALL have port o_ready, output, 1 bit, high when idle and able to accept a request.
REQ-009 SHALL have port o_lut_addr, output, ADDR_W bits, registered read address into the exp table.
REQ-010 SHALL have port i_lut_data, input, 64 bits, table word, valid one cycle after o_lut_addr is presented.
REQ-011 SHALL have port o_valid, output, 1 bit, one-cycle result strobe.
REQ-012 SHALL have port o_index, output, ADDR_W bits, resolved table index.
REQ-013 SHALL have port o_ln_value, output, 64 bits, signed q32.32 ln(x).
REQ-014 SHALL have ports o_sat_low and o_sat_high, output, 1 bit each, clamp flags, valid with o_valid.

Function
REQ-015 SHALL treat the table as monotonically increasing, with table[i] = exp(-1 + 2i/(ARRAY_SIZE-1)) in q32.32.
REQ-016 SHALL accept a request when i_valid && o_ready (cycle 0), latch i_value, and drop o_ready in cycle 1.
REQ-017 SHALL ignore i_valid while o_ready is low.
REQ-018 SHALL use states IDLE, RD_MIN, CMP_MIN, RD_MAX, CMP_MAX, RD_MID, CMP_MID and DONE.
REQ-019 SHALL present o_lut_addr=0 in cycle 1 (RD_MIN) and compare in cycle 2 (CMP_MIN); if x <= table[0], result index 0, o_sat_low=1, o_valid in cycle 3.
REQ-020 SHALL otherwise present ARRAY_SIZE-1 in cycle 3 (RD_MAX) and compare in cycle 4 (CMP_MAX); if x >= table[ARRAY_SIZE-1], result index ARRAY_SIZE-1, o_sat_high=1, o_valid in cycle 5.
REQ-021 SHALL otherwise initialise lo=0 and hi=ARRAY_SIZE-1, then run exactly ADDR_W iterations k=1..ADDR_W.
REQ-022 SHALL, in each iteration, set mid=(lo+hi)>>1, present mid in cycle 3+2k, and compare in cycle 4+2k: if table[mid] <= x then lo=mid, else hi=mid.
REQ-023 SHALL NOT terminate the search early; the iteration with hi=lo+1 leaves lo unchanged.
REQ-024 SHALL output result index=lo with o_valid in cycle 2*ADDR_W+5 (45 at default parameters).
REQ-025 SHALL perform all table comparisons as unsigned 64-bit.
REQ-026 SHALL compute o_ln_value = (index*STEP_Q) - 2^32 in at least 64-bit arithmetic, truncated to 64 bits.
REQ-027 SHALL hold o_index, o_ln_value and the sat flags stable from o_valid until the next o_valid.
REQ-028 SHALL assert o_valid for exactly one cycle and SHALL assert o_sat_low and o_sat_high mutually exclusively.
REQ-029 SHALL raise o_ready in the same cycle as o_valid, allowing back-to-back requests with the next accept in that cycle.

Reset
REQ-030 SHALL, while i_rst is high, immediately force state=IDLE, o_ready=1, o_valid=0, o_lut_addr=0, o_index=0, o_ln_value=0, o_sat_low=0 and o_sat_high=0.
REQ-031 SHALL abort any in-flight request on reset mid-search; that request SHALL produce no o_valid.

Verification
REQ-032 SHALL verify: x=0x0000_0001_0000_0000 (1.0) -> o_valid at cycle 45, o_index=499999, o_ln_value=0x0000_0000_0000_5E32, both sat flags 0.
REQ-033 SHALL verify: x=0 -> o_valid at cycle 3, o_index=0, o_sat_low=1, o_ln_value=0xFFFF_FFFF_0000_0000.
REQ-034 SHALL verify: x=0x0000_0003_0000_0000 -> o_valid at cycle 5, o_index=999999, o_sat_high=1, o_ln_value=0x0000_0001_0000_DDF2.
REQ-035 SHALL verify: x=table[0] exactly -> o_sat_low=1; x=table[999999] exactly -> o_sat_high=1; x=table[123456] exactly -> o_index=123456 at cycle 45.
REQ-036 SHALL verify: i_rst pulsed at cycle 20 of a search -> no o_valid and o_ready=1; a following request x=1.0 completes per REQ-032.
REQ-037 SHALL verify: i_valid held high continuously with alternating operands -> accepts occur only when o_ready=1, each request yields exactly one o_valid, and every intervening i_valid is ignored.

Source files
------------

// File: rtl/ln_lut_search.sv
// ---------------------------------------------------------------------------
// ln_lut_search
//
// Computes ln(x) for an unsigned q32.32 operand by binary-searching an external
// table of exp() samples. The table holds table[i] = exp(-1 + 2i/(ARRAY_SIZE-1))
// in q32.32 and is monotonically increasing. The resolved index i is turned back
// into a value by ln = i*STEP_Q - 2^32 (q32.32, signed, two's complement).
//
// The endpoints are probed first so out-of-range operands finish early with a
// clamp flag. Otherwise a fixed-length search of ADDR_W iterations runs, giving
// a constant latency for every in-range operand.
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_valid      request strobe, taken when o_ready is high
//   i_value      unsigned q32.32 operand x
//   o_ready      idle / able to accept (also high in the result cycle)
//   o_lut_addr   registered table read address
//   i_lut_data   table word, valid one cycle after o_lut_addr
//   o_valid      one-cycle result strobe
//   o_index      resolved table index (held until the next result)
//   o_ln_value   signed q32.32 ln(x)   (held until the next result)
//   o_sat_low    x <= table[0]           (held until the next result)
//   o_sat_high   x >= table[ARRAY_SIZE-1] (held until the next result)
// ---------------------------------------------------------------------------
module ln_lut_search #(
    parameter int ARRAY_SIZE = 1_000_000,
    parameter int ADDR_W     = 20,
    parameter int STEP_Q     = 8590
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [63:0]       i_value,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_lut_addr,
    input  logic [63:0]       i_lut_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_index,
    output logic [63:0]       o_ln_value,
    output logic              o_sat_low,
    output logic              o_sat_high
);

    localparam int              IW        = $clog2(ADDR_W + 1);
    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(ARRAY_SIZE - 1);
    localparam logic [IW-1:0]   LAST_ITER = IW'(ADDR_W);
    localparam logic [63:0]     ONE_Q32   = 64'h0000_0001_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_MIN,
        CMP_MIN,
        RD_MAX,
        CMP_MAX,
        RD_MID,
        CMP_MID,
        DONE
    } state_t;

    // Midpoint of the current bracket; the sum needs one extra bit.
    function automatic logic [ADDR_W-1:0] mid_of(input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi);
        logic [ADDR_W:0] sum;
        sum    = {1'b0, lo} + {1'b0, hi};
        mid_of = ADDR_W'(sum >> 1);
    endfunction

    // Index back to value: i*STEP_Q - 1.0, wrapping in 64 bits so that
    // indices below the midpoint come out as negative two's complement.
    function automatic logic [63:0] ln_of(input logic [ADDR_W-1:0] idx);
        logic [63:0] prod;
        prod  = 64'(idx) * 64'(STEP_Q);
        ln_of = prod - ONE_Q32;
    endfunction

    state_t            state_q, state_d;
    logic [63:0]       x_q, x_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [63:0]       ln_q, ln_d;
    logic              sat_lo_q, sat_lo_d;
    logic              sat_hi_q, sat_hi_d;

    // Bracket update of the current search step, shared by the next-state logic.
    logic [ADDR_W-1:0] lo_nx;
    logic [ADDR_W-1:0] hi_nx;
    logic [IW-1:0]     iter_nx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            iter_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            index_q  <= '0;
            ln_q     <= '0;
            sat_lo_q <= 1'b0;
            sat_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            iter_q   <= iter_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            index_q  <= index_d;
            ln_q     <= ln_d;
            sat_lo_q <= sat_lo_d;
            sat_hi_q <= sat_hi_d;
        end
    end

    // During CMP_MID, addr_q still holds the mid that produced i_lut_data.
    always_comb begin
        lo_nx   = lo_q;
        hi_nx   = hi_q;
        iter_nx = iter_q + 1'b1;
        if (i_lut_data <= x_q) begin
            lo_nx = addr_q;
        end else begin
            hi_nx = addr_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        iter_d   = iter_q;
        addr_d   = addr_q;
        valid_d  = 1'b0;
        index_d  = index_q;
        ln_d     = ln_q;
        sat_lo_d = sat_lo_q;
        sat_hi_d = sat_hi_q;

        case (state_q)
            // The result cycle doubles as an idle cycle so a new request can
            // be taken while o_valid is high.
            IDLE, DONE: begin
                if (i_valid) begin
                    x_d     = i_value;
                    addr_d  = '0;
                    state_d = RD_MIN;
                end else begin
                    state_d = IDLE;
                end
            end

            RD_MIN: begin
                state_d = CMP_MIN;
            end

            CMP_MIN: begin
                if (x_q <= i_lut_data) begin
                    index_d  = '0;
                    ln_d     = ln_of('0);
                    sat_lo_d = 1'b1;
                    sat_hi_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    addr_d  = MAX_IDX;
                    state_d = RD_MAX;
                end
            end

            RD_MAX: begin
                state_d = CMP_MAX;
            end

            CMP_MAX: begin
                if (x_q >= i_lut_data) begin
                    index_d  = MAX_IDX;
                    ln_d     = ln_of(MAX_IDX);
                    sat_lo_d = 1'b0;
                    sat_hi_d = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    lo_d    = '0;
                    hi_d    = MAX_IDX;
                    iter_d  = '0;
                    addr_d  = mid_of('0, MAX_IDX);
                    state_d = RD_MID;
                end
            end

            RD_MID: begin
                state_d = CMP_MID;
            end

            // Always ADDR_W iterations, no early exit: once hi == lo+1 the
            // midpoint equals lo and the bracket stops moving.
            CMP_MID: begin
                lo_d   = lo_nx;
                hi_d   = hi_nx;
                iter_d = iter_nx;
                if (iter_nx == LAST_ITER) begin
                    index_d  = lo_nx;
                    ln_d     = ln_of(lo_nx);
                    sat_lo_d = 1'b0;
                    sat_hi_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    addr_d  = mid_of(lo_nx, hi_nx);
                    state_d = RD_MID;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready    = (state_q == IDLE) || (state_q == DONE);
    assign o_lut_addr = addr_q;
    assign o_valid    = valid_q;
    assign o_index    = index_q;
    assign o_ln_value = ln_q;
    assign o_sat_low  = sat_lo_q;
    assign o_sat_high = sat_hi_q;

endmodule

// File: tb/tb_ln_lut_search.sv
module tb_ln_lut_search;

    localparam int N       = 1_000_000;
    localparam int AW      = 20;
    localparam int STEP    = 8590;
    localparam int LAT_MID = 2 * AW + 5;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [63:0]   i_value;
    logic          o_ready;
    logic [AW-1:0] o_lut_addr;
    logic [63:0]   lut_data;
    logic          o_valid;
    logic [AW-1:0] o_index;
    logic [63:0]   o_ln_value;
    logic          o_sat_low;
    logic          o_sat_high;

    int checks   = 0;
    int failures = 0;

    ln_lut_search #(.ARRAY_SIZE(N), .ADDR_W(AW), .STEP_Q(STEP)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .o_ready    (o_ready),
        .o_lut_addr (o_lut_addr),
        .i_lut_data (lut_data),
        .o_valid    (o_valid),
        .o_index    (o_index),
        .o_ln_value (o_ln_value),
        .o_sat_low  (o_sat_low),
        .o_sat_high (o_sat_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exp table contents in q32.32.
    function automatic logic [63:0] tbl(input int i);
        real r;
        r = $exp(-1.0 + 2.0 * real'(i) / real'(N - 1)) * 4294967296.0;
        return 64'(longint'(r));
    endfunction

    // External synchronous table: data one cycle after the address.
    always @(posedge clk) lut_data <= tbl(int'(o_lut_addr));

    // Reference: largest i with table[i] <= x, found by inverting exp and
    // nudging, with clamping at both ends.
    function automatic int model_idx(input logic [63:0] x);
        int  i;
        real xr;
        if (x <= tbl(0)) return 0;
        if (x >= tbl(N - 1)) return N - 1;
        xr = real'(longint'(x)) / 4294967296.0;
        i  = int'(($ln(xr) + 1.0) * real'(N - 1) / 2.0);
        if (i < 0) i = 0;
        if (i > N - 1) i = N - 1;
        while (i < N - 1 && tbl(i + 1) <= x) i++;
        while (i > 0 && tbl(i) > x) i--;
        return i;
    endfunction

    function automatic int model_lat(input logic [63:0] x);
        if (x <= tbl(0)) return 3;
        if (x >= tbl(N - 1)) return 5;
        return LAT_MID;
    endfunction

    function automatic logic [63:0] model_ln(input int idx);
        longint v;
        v = longint'(idx) * longint'(STEP) - 64'sh1_0000_0000;
        return 64'(v);
    endfunction

    // Issue one request and wait (bounded) for its result.
    task automatic run_req(input logic [63:0] x, output bit rdy1, output bit got,
                           output int n, output logic [AW-1:0] idx,
                           output logic [63:0] ln, output bit sl, output bit sh);
        got = 0; n = 0; idx = '0; ln = '0; sl = 0; sh = 0;
        @(negedge clk);
        for (int w = 0; w < 100 && !o_ready; w++) @(negedge clk);
        i_valid = 1'b1;
        i_value = x;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rdy1 = o_ready;
        for (int k = 1; k <= 100; k++) begin
            if (o_valid) begin
                got = 1; n = k; idx = o_index; ln = o_ln_value;
                sl = o_sat_low; sh = o_sat_high;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_value = '0;
        #2;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_lut_addr !== '0 || o_index !== '0 ||
            o_ln_value !== '0 || o_sat_low !== 1'b0 || o_sat_high !== 1'b0) begin
            failures++;
            $display("FAIL reset_state rdy=%b vld=%b addr=%0h idx=%0h ln=%0h sl=%b sh=%b (exp 1,0,0,0,0,0,0)",
                     o_ready, o_valid, o_lut_addr, o_index, o_ln_value, o_sat_low, o_sat_high);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_one();
        bit rdy1, got, sl, sh; int n; logic [AW-1:0] idx; logic [63:0] ln;
        logic [AW-1:0] idx_h; logic [63:0] ln_h;
        run_req(64'h0000_0001_0000_0000, rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (rdy1 !== 1'b0) begin
            failures++; $display("FAIL one_ready_drop got=%b exp=0", rdy1);
        end
        checks++;
        if (!got || n !== 45) begin
            failures++; $display("FAIL one_latency got=%0d (seen=%0b) exp=45", n, got);
        end
        checks++;
        if (idx !== AW'(499999) || ln !== 64'h5E32 || sl !== 1'b0 || sh !== 1'b0) begin
            failures++;
            $display("FAIL one_result idx=%0d ln=%h sl=%b sh=%b exp idx=499999 ln=5e32 sl=0 sh=0",
                     idx, ln, sl, sh);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++; $display("FAIL one_ready_with_valid got=%b exp=1", o_ready);
        end
        idx_h = o_index; ln_h = o_ln_value;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b0 || o_index !== idx_h || o_ln_value !== ln_h) begin
                failures++;
                $display("FAIL one_hold vld=%b idx=%0d ln=%h exp vld=0 idx=%0d ln=%h",
                         o_valid, o_index, o_ln_value, idx_h, ln_h);
            end
        end
    endtask

    task automatic test_saturate();
        bit rdy1, got, sl, sh; int n; logic [AW-1:0] idx; logic [63:0] ln;
        run_req(64'h0, rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 3 || idx !== '0 || sl !== 1'b1 || sh !== 1'b0 ||
            ln !== 64'hFFFF_FFFF_0000_0000) begin
            failures++;
            $display("FAIL sat_low_zero n=%0d idx=%0d ln=%h sl=%b sh=%b exp n=3 idx=0 ln=ffffffff00000000 sl=1 sh=0",
                     n, idx, ln, sl, sh);
        end
        run_req(64'h0000_0003_0000_0000, rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 5 || idx !== AW'(999999) || sl !== 1'b0 || sh !== 1'b1 ||
            ln !== 64'h0000_0001_0000_DDF2) begin
            failures++;
            $display("FAIL sat_high_three n=%0d idx=%0d ln=%h sl=%b sh=%b exp n=5 idx=999999 ln=100000ddf2 sl=0 sh=1",
                     n, idx, ln, sl, sh);
        end
    endtask

    task automatic test_exact();
        bit rdy1, got, sl, sh; int n; logic [AW-1:0] idx; logic [63:0] ln;
        run_req(tbl(0), rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 3 || idx !== '0 || sl !== 1'b1 || sh !== 1'b0) begin
            failures++;
            $display("FAIL exact_t0 n=%0d idx=%0d sl=%b sh=%b exp n=3 idx=0 sl=1 sh=0", n, idx, sl, sh);
        end
        run_req(tbl(N - 1), rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 5 || idx !== AW'(N - 1) || sl !== 1'b0 || sh !== 1'b1) begin
            failures++;
            $display("FAIL exact_tmax n=%0d idx=%0d sl=%b sh=%b exp n=5 idx=999999 sl=0 sh=1", n, idx, sl, sh);
        end
        run_req(tbl(123456), rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 45 || idx !== AW'(123456) || sl || sh || ln !== model_ln(123456)) begin
            failures++;
            $display("FAIL exact_t123456 n=%0d idx=%0d ln=%h exp n=45 idx=123456 ln=%h",
                     n, idx, ln, model_ln(123456));
        end
        run_req(tbl(1), rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 45 || idx !== AW'(1) || sl || sh) begin
            failures++;
            $display("FAIL exact_t1 n=%0d idx=%0d sl=%b sh=%b exp n=45 idx=1", n, idx, sl, sh);
        end
        run_req(tbl(N - 1) - 64'd1, rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 45 || idx !== AW'(N - 2) || sl || sh) begin
            failures++;
            $display("FAIL below_tmax n=%0d idx=%0d sl=%b sh=%b exp n=45 idx=%0d", n, idx, sl, sh, N - 2);
        end
    endtask

    task automatic test_random();
        bit rdy1, got, sl, sh; int n; logic [AW-1:0] idx; logic [63:0] ln;
        logic [63:0] lo, span, x; int ei, el;
        lo   = tbl(0) - 64'd2000;
        span = tbl(N - 1) - tbl(0) + 64'd4000;
        for (int t = 0; t < 16; t++) begin
            x  = lo + ({$urandom, $urandom} % span);
            ei = model_idx(x);
            el = model_lat(x);
            run_req(x, rdy1, got, n, idx, ln, sl, sh);
            checks++;
            if (!got || n !== el || idx !== AW'(ei) || ln !== model_ln(ei) ||
                sl !== (ei == 0 && el == 3) || sh !== (el == 5)) begin
                failures++;
                $display("FAIL random x=%h n=%0d idx=%0d ln=%h sl=%b sh=%b exp n=%0d idx=%0d ln=%h",
                         x, n, idx, ln, sl, sh, el, ei, model_ln(ei));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen; bit rdy1, got, sl, sh; int n; logic [AW-1:0] idx; logic [63:0] ln;
        @(negedge clk);
        i_valid = 1'b1;
        i_value = 64'h0000_0001_0000_0000;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_lut_addr !== '0 || o_index !== '0 ||
            o_ln_value !== '0 || o_sat_low !== 1'b0 || o_sat_high !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state rdy=%b vld=%b addr=%0h idx=%0h ln=%0h exp 1,0,0,0,0",
                     o_ready, o_valid, o_lut_addr, o_index, o_ln_value);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_valid got=%b exp=0", seen);
        end
        run_req(64'h0000_0001_0000_0000, rdy1, got, n, idx, ln, sl, sh);
        checks++;
        if (!got || n !== 45 || idx !== AW'(499999) || ln !== 64'h5E32 || sl || sh) begin
            failures++;
            $display("FAIL reset_mid_after n=%0d idx=%0d ln=%h exp n=45 idx=499999 ln=5e32", n, idx, ln);
        end
    endtask

    typedef struct {
        logic [63:0] x;
        int          acc;
    } req_t;

    task automatic test_back_to_back();
        req_t q[$];
        req_t r;
        logic [63:0] a, b, x;
        int accepts, valids, cyc, ei, el, bad;
        a = 64'h0;
        b = tbl(0) + ({32'h0, $urandom} % (tbl(N - 1) - tbl(0)));
        accepts = 0; valids = 0; bad = 0;
        @(negedge clk);
        for (cyc = 1; cyc <= 500; cyc++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                valids++;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b_unexpected_valid cycle=%0d", cyc);
                end else begin
                    r  = q.pop_front();
                    ei = model_idx(r.x);
                    el = model_lat(r.x);
                    checks++;
                    if (cyc !== r.acc + el || o_index !== AW'(ei) || o_ln_value !== model_ln(ei) ||
                        o_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_result cycle=%0d idx=%0d rdy=%b exp cycle=%0d idx=%0d rdy=1",
                                 cyc, o_index, o_ready, r.acc + el, ei);
                    end
                end
            end
            if (cyc <= 400) begin
                x = (cyc % 2 == 0) ? a : b;
                i_valid = 1'b1;
                i_value = x;
                if (o_ready) begin
                    r.x = x; r.acc = cyc;
                    q.push_back(r);
                    accepts++;
                end
            end else begin
                i_valid = 1'b0;
            end
        end
        checks++;
        if (q.size() != 0 || accepts != valids || accepts < 10) begin
            failures++;
            $display("FAIL b2b_counts accepts=%0d valids=%0d pending=%0d exp equal, none pending",
                     accepts, valids, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_one();
        test_saturate();
        test_exact();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
